imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//  Boot-time writer for the processor's 4096-word instruction memory: receives a program
//  image over a UART RX line (8N1) and writes it word by word into the imem write port.
//  Holds the processor in reset (cpu_rst) until the image is fully and correctly loaded.
//  Sits between the board RX pin and the imem in/we/addr port; the processor then only reads imem.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 4
//  ADDR_WIDTH    12   imem word-address width; capacity 2**ADDR_WIDTH words
// PORTS
//  clk      in   1           system clock
//  rst      in   1           synchronous, active-high reset
//  rxd      in   1           UART serial input, idle high, asynchronous to clk
//  we       out  1           imem write enable, one-cycle pulse per word
//  addr     out  ADDR_WIDTH  imem word address (byte address >> 2)
//  wdata    out  32          imem write data
//  cpu_rst  out  1           processor reset; 1 until load done
//  done     out  1           image loaded, sticky until rst
//  err      out  1           framing/length/checksum error, sticky until rst
// BEHAVIOUR
//  Reset: we=0, addr=0, wdata=0, cpu_rst=1, done=0, err=0; FSM->S_LEN; byte/bit counters 0.
//  rst mid-load aborts: partial words discarded, next image restarts at addr 0.
//  RX: rxd through 2-FF synchroniser. Start = sync rxd low; re-check at CLKS_PER_BIT/2;
//   if high again, glitch ignored. 8 data bits LSB first sampled at bit centres, then stop bit.
//   Stop bit 0 -> framing error -> S_ERR. byte_vld pulses 1 cycle at stop-bit sample.
//  Stream format: 4-byte word count N (big-endian), then N words, each 4 bytes big-endian
//   (first byte -> wdata[31:24]); with IMEM_LOADER_CKSUM_EN one trailing checksum byte.
//  FSM: S_LEN --4th byte--> N==0 ? (S_CKSUM|S_DONE) : N>2**ADDR_WIDTH ? S_ERR : S_DATA
//       S_DATA --4th byte of word--> we=1 next cycle, wdata=word, addr=word index;
//         addr increments the cycle after the pulse; after word N -> S_CKSUM|S_DONE
//       S_CKSUM --byte--> match ? S_DONE : S_ERR
//       S_DONE: done=1, cpu_rst=0 (cycle after last we, or after cksum byte); RX bytes ignored
//       S_ERR : err=1, cpu_rst=1, no further we; RX ignored until rst
//  Latency: we asserts exactly 1 cycle after byte_vld of the word's 4th byte.
//  N == 2**ADDR_WIDTH accepted; addr wraps to 0 after last write (no further writes).
//  cpu_rst is registered; never 0 while any we may still occur.
// CONFIGURATION
//  IMEM_LOADER_CKSUM_EN defined: after the N words, one byte = (sum of all data bytes,
//   excluding length bytes) mod 256 must follow; mismatch -> S_ERR, cpu_rst stays 1.
//  Not defined: no checksum byte; S_DATA goes directly to S_DONE after word N.
// TESTING (CLKS_PER_BIT=4, ADDR_WIDTH=12)
//  1 send 00 00 00 02 24 08 00 05 01 09 50 20 -> we@addr0 wdata=0x24080005, we@addr1
//    wdata=0x01095020; done=1, cpu_rst=0 one cycle after 2nd we (cksum off)
//  2 send 00 00 00 00 -> no we; done=1, cpu_rst=0 after 4th byte (cksum off)
//  3 length 00 00 10 01 (4097) -> err=1 after 4th byte, no we, cpu_rst=1
//  4 stop bit forced 0 on 3rd byte of word 0 -> err=1, no we, cpu_rst=1; later bytes ignored
//  5 rst asserted after 6 bytes of test 1, then full resend -> writes start at addr0, same data
//  6 CKSUM_EN: test 1 stream + AB -> done=1; + AC -> err=1, cpu_rst=1 (both words still written)
//  also: 1-cycle low glitch on idle rxd -> no byte_vld, state unchanged

Source files
------------

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// The loader uses the master side and imem uses the slave side.
interface imem_uart_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;

    modport master (output we, addr, wdata);
    modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed program image over UART 8N1 and writes it into imem.
// Optional feature macro IMEM_LOADER_CKSUM_EN adds a trailing mod-256 checksum byte to the image.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rxd,
    imem_uart_loader_if.master bus,
    output logic               cpu_rst,
    output logic               done,
    output logic               err
);
    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]     MAX_WORDS = 32'(2 ** ADDR_WIDTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CKSUM, S_DONE, S_ERR} state_t;

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t AFTER_DATA = S_CKSUM;
`else
    localparam state_t AFTER_DATA = S_DONE;
`endif

    rx_state_t           rx_state, rx_state_next;
    logic                rxd_meta, rxd_sync;
    logic [CW-1:0]       clk_cnt, clk_cnt_next;
    logic [2:0]          bit_cnt, bit_cnt_next;
    logic [7:0]          rx_byte, rx_byte_next;
    logic                byte_vld, frame_err;

    state_t              state, state_next;
    logic [1:0]          byte_cnt;
    logic [23:0]         shreg;
    logic [31:0]         word_in;
    logic [ADDR_WIDTH:0] n_words, word_cnt;
    logic                word_vld, last_word;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]          sum;
`endif

    // Receiver registers; rxd is asynchronous so it passes a two-flop synchroniser first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_byte  <= '0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rx_state <= rx_state_next;
            clk_cnt  <= clk_cnt_next;
            bit_cnt  <= bit_cnt_next;
            rx_byte  <= rx_byte_next;
        end
    end

    // A start bit must still be low at its centre, otherwise it was a glitch.
    always_comb begin
        rx_state_next = rx_state;
        clk_cnt_next  = clk_cnt + 1'b1;
        bit_cnt_next  = bit_cnt;
        rx_byte_next  = rx_byte;
        byte_vld      = 1'b0;
        frame_err     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                clk_cnt_next = '0;
                if (!rxd_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_next  = '0;
                    rx_state_next = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_next = '0;
                    rx_byte_next = {rxd_sync, rx_byte[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_next  = '0;
                    rx_state_next = RX_IDLE;
                    byte_vld      = rxd_sync;
                    frame_err     = !rxd_sync;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign word_in   = {shreg, rx_byte};
    assign word_vld  = byte_vld && (byte_cnt == 2'd3);
    assign last_word = (word_cnt == n_words - 1'b1);

    always_comb begin
        state_next = state;
        case (state)
            S_LEN: begin
                if (frame_err)                  state_next = S_ERR;
                else if (word_vld) begin
                    if (word_in == '0)          state_next = AFTER_DATA;
                    else if (word_in > MAX_WORDS) state_next = S_ERR;
                    else                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (frame_err)                  state_next = S_ERR;
                else if (word_vld && last_word) state_next = AFTER_DATA;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (frame_err)                  state_next = S_ERR;
                else if (byte_vld)              state_next = (rx_byte == sum) ? S_DONE : S_ERR;
            end
`endif
            default: state_next = state;
        endcase
    end

    // Status outputs follow the state one cycle late, so cpu_rst releases only after the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LEN;
            byte_cnt  <= '0;
            shreg     <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state  <= state_next;
            bus.we <= 1'b0;
            if (byte_vld && (state == S_LEN || state == S_DATA)) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= {shreg[15:0], rx_byte};
            end
            if (state == S_LEN && word_vld) n_words <= word_in[ADDR_WIDTH:0];
            if (state == S_DATA && word_vld) begin
                bus.we    <= 1'b1;
                bus.wdata <= word_in;
                word_cnt  <= word_cnt + 1'b1;
            end
            if (bus.we) bus.addr <= bus.addr + 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            if (state == S_DATA && byte_vld) sum <= sum + rx_byte;
`endif
            cpu_rst <= (state != S_DONE);
            done    <= (state == S_DONE);
            err     <= (state == S_ERR);
        end
    end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed and randomized bench for imem_uart_loader with a queue-based model of the image writes.
// Build with IMEM_LOADER_CKSUM_EN defined to exercise the checksum trailer as well.
module tb_imem_uart_loader;
    localparam int CPB = 4;
    localparam int AW  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic cpu_rst, done, err;

    imem_uart_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int last_we_cycle = -1;
    int done_cycle    = -1;
    logic done_d = 1'b0;
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [31:0]   words[$];
    logic [7:0]    stream[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cycle++;

    // Write monitor: logs every imem write and notes when done first rises.
    always @(negedge clk) begin
        if (!rst && bus.we) begin
            wr_addr_q.push_back(bus.addr);
            wr_data_q.push_back(bus.wdata);
            last_we_cycle = cycle;
            check("cpu_rst_during_we", {31'b0, cpu_rst}, 32'd1);
        end
        if (done && !done_d && done_cycle < 0) done_cycle = cycle;
        done_d = done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 1'b1;
        tick(3);
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        last_we_cycle = -1;
        done_cycle    = -1;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = !bad_stop;
        tick(CPB);
        rxd = 1'b1;
        tick($urandom_range(1, 3));
    endtask

    // Image layout: big-endian word count, big-endian words, optional checksum of the data bytes.
    task automatic build_stream();
        int unsigned n;
        logic [7:0] s;
        n = words.size();
        s = 8'h00;
        stream.delete();
        for (int k = 3; k >= 0; k--) stream.push_back(8'((n >> (8 * k)) & 8'hFF));
        foreach (words[i])
            for (int k = 3; k >= 0; k--) begin
                stream.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
                s = s + 8'((words[i] >> (8 * k)) & 32'hFF);
            end
`ifdef IMEM_LOADER_CKSUM_EN
        stream.push_back(s);
`endif
    endtask

    task automatic send_stream(input int upto, input int bad_idx);
        for (int i = 0; i < upto; i++) send_byte(stream[i], i == bad_idx);
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || err) && k < 100) begin
            tick(1);
            k++;
        end
        tick(3);
    endtask

    task automatic expect_success(input string tag);
        int n;
        n = words.size();
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_cpu_rst"}, {31'b0, cpu_rst}, 32'd0);
        check({tag, "_wr_count"}, wr_data_q.size(), n);
        for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
            check({tag, "_addr"}, {20'b0, wr_addr_q[i]}, i % (2 ** AW));
            check({tag, "_wdata"}, wr_data_q[i], words[i]);
        end
        check({tag, "_final_addr"}, {20'b0, bus.addr}, n % (2 ** AW));
`ifndef IMEM_LOADER_CKSUM_EN
        if (n > 0) check({tag, "_done_latency"}, done_cycle - last_we_cycle, 1);
`endif
    endtask

    task automatic expect_error(input string tag);
        check({tag, "_err"}, {31'b0, err}, 32'd1);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_cpu_rst"}, {31'b0, cpu_rst}, 32'd1);
    endtask

    initial begin
        do_reset();
        check("reset_we", {31'b0, bus.we}, 32'd0);
        check("reset_addr", {20'b0, bus.addr}, 32'd0);
        check("reset_wdata", bus.wdata, 32'd0);
        check("reset_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);

        // Two-word reference image.
        words = '{32'h24080005, 32'h01095020};
        build_stream();
        send_stream(stream.size(), -1);
        wait_end();
        expect_success("t1");

        // Empty image.
        do_reset();
        words.delete();
        build_stream();
        send_stream(stream.size(), -1);
        wait_end();
        expect_success("t2");

        // Word count one above capacity.
        do_reset();
        stream = '{8'h00, 8'h00, 8'h10, 8'h01};
        send_stream(4, -1);
        wait_end();
        expect_error("t3");
        check("t3_wr_count", wr_data_q.size(), 0);

        // Word count exactly at capacity is accepted and loading continues.
        do_reset();
        stream = '{8'h00, 8'h00, 8'h10, 8'h00};
        send_stream(4, -1);
        tick(20);
        check("cap_err", {31'b0, err}, 32'd0);
        check("cap_done", {31'b0, done}, 32'd0);
        check("cap_cpu_rst", {31'b0, cpu_rst}, 32'd1);

        // Framing error on the third byte of word 0; the rest of the image must be ignored.
        do_reset();
        words = '{32'h24080005, 32'h01095020};
        build_stream();
        send_stream(stream.size(), 6);
        wait_end();
        expect_error("t4");
        check("t4_wr_count", wr_data_q.size(), 0);

        // Reset mid-load then full resend.
        do_reset();
        send_stream(6, -1);
        do_reset();
        send_stream(stream.size(), -1);
        wait_end();
        expect_success("t5");

        // Idle-line glitch must not disturb the receiver.
        do_reset();
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(20);
        check("glitch_wr_count", wr_data_q.size(), 0);
        check("glitch_done", {31'b0, done}, 32'd0);
        check("glitch_err", {31'b0, err}, 32'd0);
        words = '{$urandom(), $urandom(), $urandom()};
        build_stream();
        send_stream(stream.size(), -1);
        wait_end();
        expect_success("glitch_then_load");

        // Randomized images.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            words.delete();
            for (int i = 0; i < $urandom_range(1, 5); i++) words.push_back($urandom());
            build_stream();
            send_stream(stream.size(), -1);
            wait_end();
            expect_success("rand");
        end

`ifdef IMEM_LOADER_CKSUM_EN
        // Wrong checksum: words are still written but loading fails.
        do_reset();
        words = '{32'h24080005, 32'h01095020};
        build_stream();
        check("t6_cksum_byte", {24'b0, stream[stream.size() - 1]}, 32'hAB);
        stream[stream.size() - 1] = 8'hAC;
        send_stream(stream.size(), -1);
        wait_end();
        expect_error("t6");
        check("t6_wr_count", wr_data_q.size(), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
